// File: rtl/stack_unit.sv
// LIFO stack for PUSH/POP in the EX stage. A pop result is registered into
// the EX/DM boundary, and overflow/underflow are sticky status flags.
module stack_unit #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_EX_DM,
   input  logic             stack_push_ID_EX,
   input  logic             stack_pop_ID_EX,
   input  logic [WIDTH-1:0] stack_w_data_ID_EX,
   input  logic             clr_err,
   output logic [WIDTH-1:0] stack_EX_DM,
   output logic             stack_pop_EX_DM,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             stack_ovfl,
   output logic             stack_unfl
);

   localparam logic [PTR_W:0] SP_MAX = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] SP_ONE = {{PTR_W{1'b0}}, 1'b1};

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PTR_W:0]              sp;
   logic [PTR_W:0]              sp_m1;
   logic [PTR_W-1:0]            wr_idx, top_idx;
   logic                        push, pop, push_only, pop_only, swap;
   logic                        ovfl_set, unfl_set;

   assign stack_full  = (sp == SP_MAX);
   assign stack_empty = (sp == '0);

   assign sp_m1   = sp - SP_ONE;
   assign wr_idx  = sp[PTR_W-1:0];
   assign top_idx = sp_m1[PTR_W-1:0];

   // All operations are gated by stall and reset here, so the registers below
   // only need to decode the operation class.
   assign push      = stack_push_ID_EX & ~stall_EX_DM & ~rst;
   assign pop       = stack_pop_ID_EX  & ~stall_EX_DM & ~rst;
   assign push_only = push & ~pop;
   assign pop_only  = pop & ~push;
   assign swap      = push & pop & ~stack_empty;
   assign ovfl_set  = push_only & stack_full;
   assign unfl_set  = pop_only & stack_empty;

   // Entry storage is deliberately left without reset.
   always_ff @(posedge clk) begin
      if (push_only && !stack_full)
         mem[wr_idx] <= stack_w_data_ID_EX;
      else if (swap)
         mem[top_idx] <= stack_w_data_ID_EX;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp              <= '0;
         stack_EX_DM     <= '0;
         stack_pop_EX_DM <= 1'b0;
         stack_ovfl      <= 1'b0;
         stack_unfl      <= 1'b0;
      end else if (!stall_EX_DM) begin
         stack_pop_EX_DM <= pop;
         if (pop) begin
            if (!stack_empty)   stack_EX_DM <= mem[top_idx];
            else if (push)      stack_EX_DM <= stack_w_data_ID_EX;
            else                stack_EX_DM <= '0;
         end
         if (push_only && !stack_full)     sp <= sp + SP_ONE;
         else if (pop_only && !stack_empty) sp <= sp_m1;
         // A set in the same cycle as clr_err wins.
         stack_ovfl <= ovfl_set | (stack_ovfl & ~clr_err);
         stack_unfl <= unfl_set | (stack_unfl & ~clr_err);
      end
   end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: queue-based reference model compared
// every cycle, plus directed literal expectations.
module tb_stack_unit;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             rst, stall, push, pop, clr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] q_data;
   logic             q_pv, full, empty, ovfl, unfl;

   int checks = 0;
   int failures = 0;
   bit en = 1'b0;

   stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(4)) dut (
      .clk(clk), .rst(rst), .stall_EX_DM(stall),
      .stack_push_ID_EX(push), .stack_pop_ID_EX(pop),
      .stack_w_data_ID_EX(wdata), .clr_err(clr),
      .stack_EX_DM(q_data), .stack_pop_EX_DM(q_pv),
      .stack_full(full), .stack_empty(empty),
      .stack_ovfl(ovfl), .stack_unfl(unfl)
   );

   always #5 clk = ~clk;

   // reference model
   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] m_data;
   logic             m_pv, m_ovfl, m_unfl;

   always @(posedge clk) begin
      bit so, su;
      so = 1'b0;
      su = 1'b0;
      if (rst) begin
         mq.delete();
         m_data = '0; m_pv = 1'b0; m_ovfl = 1'b0; m_unfl = 1'b0;
      end else if (!stall) begin
         if (push && pop) begin
            m_pv = 1'b1;
            if (mq.size() == 0) m_data = wdata;
            else begin
               m_data = mq[$];
               mq[$] = wdata;
            end
         end else if (push) begin
            m_pv = 1'b0;
            if (mq.size() == DEPTH) so = 1'b1;
            else mq.push_back(wdata);
         end else if (pop) begin
            m_pv = 1'b1;
            if (mq.size() == 0) begin
               m_data = '0;
               su = 1'b1;
            end else m_data = mq.pop_back();
         end else m_pv = 1'b0;
         m_ovfl = so | (m_ovfl & ~clr);
         m_unfl = su | (m_unfl & ~clr);
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      if (en) begin
         chk("m_data",  q_data, m_data);
         chk("m_pv",    32'(q_pv), 32'(m_pv));
         chk("m_full",  32'(full), 32'(mq.size() == DEPTH));
         chk("m_empty", 32'(empty), 32'(mq.size() == 0));
         chk("m_ovfl",  32'(ovfl), 32'(m_ovfl));
         chk("m_unfl",  32'(unfl), 32'(m_unfl));
         chk("m_sp",    32'(dut.sp), 32'(mq.size()));
      end
   end

   // drive one cycle, return at the following falling edge
   task automatic tick(input logic pu, input logic po, input logic [31:0] d,
                       input logic st = 1'b0, input logic cl = 1'b0,
                       input logic r = 1'b0);
      push = pu; pop = po; wdata = d; stall = st; clr = cl; rst = r;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; wdata = '0;
      @(negedge clk);
      @(negedge clk);
      en = 1'b1;
      chk("rst_data", q_data, 32'h0);
      chk("rst_pv", 32'(q_pv), 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_full", 32'(full), 32'h0);

      // 1: LIFO order
      tick(1, 0, 32'hA); tick(1, 0, 32'hB); tick(1, 0, 32'hC);
      tick(0, 1, 0); chk("t1_pop0", q_data, 32'hC); chk("t1_pv0", 32'(q_pv), 1);
      tick(0, 1, 0); chk("t1_pop1", q_data, 32'hB);
      tick(0, 1, 0); chk("t1_pop2", q_data, 32'hA); chk("t1_empty", 32'(empty), 1);
      tick(0, 0, 0); chk("t1_idle_pv", 32'(q_pv), 0); chk("t1_hold", q_data, 32'hA);

      // 2: fill, overflow, pop
      for (int i = 0; i < DEPTH; i++) tick(1, 0, 32'(i));
      chk("t2_full", 32'(full), 1);
      tick(1, 0, 32'h99);
      chk("t2_sp", 32'(dut.sp), 16); chk("t2_ovfl", 32'(ovfl), 1);
      tick(0, 1, 0); chk("t2_pop", q_data, 32'hF);
      tick(0, 0, 0, 0, 1); chk("t2_clr", 32'(ovfl), 0);
      // swap on a full stack must not overflow
      tick(1, 0, 32'h55);
      tick(1, 1, 32'hAA); chk("t2_fswap", q_data, 32'h55); chk("t2_fswap_ovfl", 32'(ovfl), 0);
      tick(0, 1, 0); chk("t2_fswap_pop", q_data, 32'hAA);
      for (int i = 0; i < DEPTH - 1; i++) tick(0, 1, 0);
      chk("t2_drained", 32'(empty), 1); chk("t2_last", q_data, 32'h0);

      // 3: underflow and clear; set beats clear
      tick(0, 1, 0);
      chk("t3_data", q_data, 0); chk("t3_pv", 32'(q_pv), 1); chk("t3_unfl", 32'(unfl), 1);
      tick(0, 0, 0, 0, 1); chk("t3_clr", 32'(unfl), 0);
      tick(0, 1, 0, 0, 1); chk("t3_setwins", 32'(unfl), 1);
      tick(0, 0, 0, 1, 1); chk("t3_clr_stalled", 32'(unfl), 1);
      tick(0, 0, 0, 0, 1); chk("t3_clr2", 32'(unfl), 0);

      // 4: swap and empty bypass
      tick(1, 0, 32'h5);
      tick(1, 1, 32'h7); chk("t4_swap", q_data, 32'h5); chk("t4_sp", 32'(dut.sp), 1);
      tick(0, 1, 0); chk("t4_pop", q_data, 32'h7);
      tick(1, 1, 32'h3); chk("t4_bypass", q_data, 32'h3); chk("t4_bp_sp", 32'(dut.sp), 0);
      chk("t4_bp_unfl", 32'(unfl), 0);

      // 5: stall holds a pop
      tick(1, 0, 32'h42);
      tick(0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick(0, 1, 0, 1);
         chk("t5_st_pv", 32'(q_pv), 0); chk("t5_st_sp", 32'(dut.sp), 1);
         chk("t5_st_data", q_data, 32'h3);
      end
      tick(0, 1, 0); chk("t5_pop", q_data, 32'h42); chk("t5_pv", 32'(q_pv), 1);
      tick(0, 0, 0); chk("t5_once", 32'(q_pv), 0);

      // 6: reset during a pop, with a sticky flag set beforehand
      tick(0, 1, 0);
      tick(1, 0, 32'h1); tick(1, 0, 32'h2);
      tick(0, 1, 0, 0, 0, 1);
      chk("t6_sp", 32'(dut.sp), 0); chk("t6_data", q_data, 0);
      chk("t6_pv", 32'(q_pv), 0); chk("t6_empty", 32'(empty), 1);
      chk("t6_unfl", 32'(unfl), 0); chk("t6_ovfl", 32'(ovfl), 0);
      tick(0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
